fifo_wr_arbiter: RTL and testbench
==================================

Name: fifo_wr_arbiter

Overview:
- Shares the single write port of the async FIFO controller between NREQ producers in the write clock domain.
- Grants whole bursts in round-robin order, only when the FIFO has room for the complete burst.
- Drives the FIFO wen/wdata and returns per-word acks to the winning producer.
- Uses the controller's full and gauge outputs as flow-control inputs.

Parameters:
- NREQ, 4, number of requesters (2..8).
- DW, 8, data word width.
- GW, 6, width of the gauge input.
- CAP, 32, usable FIFO capacity in words (33-slot ring, one slot kept empty).
- LW, 4, width of each burst-length field; maximum burst is 2^LW-1 = 15.

Ports:
- clk  in  1  write-domain clock; all logic on its rising edge.
- srst  in  1  synchronous, active-high reset.
- req  in  NREQ  per-requester burst request; held high until its burst completes.
- len  in  NREQ*LW  per-requester burst length, slice i for requester i; 0 is treated as 1.
- din  in  NREQ*DW  per-requester write data, slice i for requester i.
- full  in  1  FIFO full flag.
- gauge  in  GW  FIFO occupancy, 0..CAP.
- ack  out  NREQ  one-hot per-word accept; the owner presents its next word on the following cycle.
- grant  out  NREQ  one-hot registered burst owner; 0 when idle.
- wen  out  1  FIFO write enable.
- wdata  out  DW  FIFO write data, equal to din slice of the owner.
- busy  out  1  high while in XFER.
- abort  out  1  one-cycle pulse when a burst ends early.

Behaviour:
- Reset: state=IDLE, grant=0, busy=0, abort=0, count=0, rr pointer=NREQ-1, so requester 0 has top priority first.
- Combinational outputs: wen, ack and wdata are driven from the registered grant.
  - wen = (state==XFER) && req[owner] && !full.
  - ack[owner] = wen; all other ack bits are 0.
  - wdata = din[owner] whenever grant is non-zero, else 0.
- free = CAP - gauge, computed at GW+1 bits unsigned. A gauge value above CAP saturates free to 0.
- IDLE:
  - Candidate = first i with req[i]=1, scanning from rr+1 upward with wrap.
  - If eff_len(candidate) <= free: grant <= onehot(candidate), count <= eff_len, state <= XFER. eff_len is len, or 1 when len is 0.
  - Otherwise stay in IDLE. The candidate is not skipped, so a long burst cannot be starved by shorter ones.
  - No request present: stay in IDLE.
- XFER:
  - Each wen cycle decrements count.
  - wen with count==1: state <= IDLE, grant <= 0, rr <= owner index.
  - full asserted: stall. wen=0 and count is held; no abort.
  - req[owner] low: burst is cut. state <= IDLE, grant <= 0, rr <= owner, abort=1 for one cycle. wen is 0 that cycle, so no word is written.
- Latency:
  - Request seen in IDLE, grant high the next cycle, first wen in that same cycle.
  - Back-to-back bursts always have exactly one IDLE bubble between them.
- len and din of the owner are sampled at grant time (len) or per word (din). Changes to len mid-burst are ignored.
- srst mid-burst: the next cycle shows all reset values. No abort pulse and no wen. Words already written stay in the FIFO.
- Single requester: rr rotates back to the same requester, so it can win repeatedly with one bubble between bursts.

Decomposition:
- Package fifo_ctrl_pkg:
  - typedef enum {IDLE, XFER} arb_state_t.
  - localparam CAP=32.
  - Function eff_len, mapping 0 to 1.
- Sub-module rr_pick: purely combinational round-robin pick.
  - Inputs: req vector and rr pointer.
  - Outputs: valid and index.
  - Instantiated once inside fifo_wr_arbiter.

Test Plan:
- req=0001, len0=4, gauge=0 → grant=0001 at cycle 1, wen high cycles 1-4, ack[0] four pulses, back to IDLE at cycle 5, rr=0.
- req=1111 held, all len=2, FIFO drained continuously → grant order 0,1,2,3,0, with one idle cycle between bursts.
- gauge=30, len0=3 → no grant. gauge drops to 29 → grant next cycle, exactly 3 wen.
- In XFER, full high for cycles 2-3 of a 5-word burst → wen low those two cycles, burst completes with exactly 5 wen, no abort.
- req[1] dropped after 2 of 6 words → abort pulses once, grant=0 next cycle, rr=1, next winner is requester 2 when it is requesting.
- srst high during cycle 3 of a burst → next cycle grant=0, wen=0, busy=0, abort=0. After release, requester 0 wins first.

Source files
------------

// File: rtl/fifo_ctrl_pkg.sv
// Shared types, constants and helpers for the FIFO write-side arbiter.
package fifo_ctrl_pkg;

    // Arbiter FSM: waiting for a burst that fits, or streaming one burst.
    typedef enum logic [0:0] {
        IDLE = 1'b0,
        XFER = 1'b1
    } arb_state_t;

    // Usable FIFO capacity in words (33-slot ring, one slot kept empty).
    localparam int CAP = 32;

    // A zero burst length still moves one word.
    function automatic int unsigned eff_len(input int unsigned len_in);
        return (len_in == 0) ? 32'd1 : len_in;
    endfunction

endpackage

// File: rtl/fifo_wr_arbiter_rr_pick.sv
// Combinational round-robin pick: first requester after the pointer, with wrap.
module rr_pick #(
    parameter int NREQ = 4,
    parameter int IW   = 2
) (
    input  logic [NREQ-1:0] req,
    input  logic [IW-1:0]   rr,
    output logic            valid,
    output logic [IW-1:0]   idx
);

    int unsigned w_i;

    // Scan from the farthest position down so the nearest request after rr wins.
    always_comb begin
        valid = 1'b0;
        idx   = '0;
        w_i   = 0;
        for (int k = NREQ; k >= 1; k--) begin
            w_i = (32'(rr) + 32'(k)) % 32'(NREQ);
            if (req[w_i]) begin
                valid = 1'b1;
                idx   = IW'(w_i);
            end
        end
    end

endmodule

// File: rtl/fifo_wr_arbiter.sv
// Round-robin burst arbiter for the single write port of the async FIFO.
// A burst is granted only when the whole burst fits in the free space; the
// owner then streams words, stalling on full, until its count runs out or it
// drops its request (which ends the burst early with an abort pulse).
//
// Handshake: ack[i] is a per-word accept. In any cycle where ack[i] is high the
// word on din slice i is written; the owner presents its next word on the
// following cycle. req[i] must stay high until the burst completes.
module fifo_wr_arbiter #(
    parameter int NREQ = 4,
    parameter int DW   = 8,
    parameter int GW   = 6,
    parameter int CAP  = fifo_ctrl_pkg::CAP,
    parameter int LW   = 4,
    localparam int IW  = (NREQ > 1) ? $clog2(NREQ) : 1
) (
    input  logic                     clk,
    input  logic                     srst,
    input  logic [NREQ-1:0]          req,
    input  logic [NREQ*LW-1:0]       len,
    input  logic [NREQ*DW-1:0]       din,
    input  logic                     full,
    input  logic [GW-1:0]            gauge,
    output logic [NREQ-1:0]          ack,
    output logic [NREQ-1:0]          grant,
    output logic                     wen,
    output logic [DW-1:0]            wdata,
    output logic                     busy,
    output logic                     abort,
    output fifo_ctrl_pkg::arb_state_t dbg_state,
    output logic [IW-1:0]            dbg_rr
);

    import fifo_ctrl_pkg::*;

    arb_state_t      r_state;
    logic [NREQ-1:0] r_grant;
    logic [IW-1:0]   r_owner;
    logic [LW-1:0]   r_count;
    logic [IW-1:0]   r_rr;

    arb_state_t      w_state_nxt;
    logic [NREQ-1:0] w_grant_nxt;
    logic [IW-1:0]   w_owner_nxt;
    logic [LW-1:0]   w_count_nxt;
    logic [IW-1:0]   w_rr_nxt;

    logic            w_pick_valid;
    logic [IW-1:0]   w_pick_idx;
    logic [LW-1:0]   w_cand_len;
    logic [LW-1:0]   w_cand_eff;
    logic [GW:0]     w_cap;
    logic [GW:0]     w_gauge_ext;
    logic [GW:0]     w_free;
    logic            w_fits;
    logic            w_owner_req;
    logic            w_xfer;

    rr_pick #(
        .NREQ (NREQ),
        .IW   (IW)
    ) u_rr_pick (
        .req   (req),
        .rr    (r_rr),
        .valid (w_pick_valid),
        .idx   (w_pick_idx)
    );

    // Free space, saturating at zero if gauge ever reports more than CAP.
    always_comb begin
        w_cap       = (GW+1)'(CAP);
        w_gauge_ext = {1'b0, gauge};
        w_free      = (w_gauge_ext > w_cap) ? '0 : (w_cap - w_gauge_ext);
        w_cand_len  = len[w_pick_idx*LW +: LW];
        w_cand_eff  = LW'(eff_len(32'(w_cand_len)));
        w_fits      = (32'(w_cand_eff) <= 32'(w_free));
    end

    // Write-port outputs, all derived from the registered owner.
    always_comb begin
        w_xfer      = (r_state == XFER);
        w_owner_req = req[r_owner];
        wen         = w_xfer && w_owner_req && !full;
        ack         = wen ? r_grant : '0;
        wdata       = (r_grant != '0) ? din[r_owner*DW +: DW] : '0;
        busy        = w_xfer;
        abort       = w_xfer && !w_owner_req;
        grant       = r_grant;
        dbg_state   = r_state;
        dbg_rr      = r_rr;
    end

    // Next-state logic: grant a fitting burst, count words, end or cut bursts.
    always_comb begin
        w_state_nxt = r_state;
        w_grant_nxt = r_grant;
        w_owner_nxt = r_owner;
        w_count_nxt = r_count;
        w_rr_nxt    = r_rr;
        case (r_state)
            IDLE: begin
                // The candidate is never skipped, so a long burst waits for room
                // rather than being starved by shorter ones behind it.
                if (w_pick_valid && w_fits) begin
                    w_state_nxt = XFER;
                    w_grant_nxt = NREQ'(1) << w_pick_idx;
                    w_owner_nxt = w_pick_idx;
                    w_count_nxt = w_cand_eff;
                end
            end
            XFER: begin
                if (!w_owner_req) begin
                    w_state_nxt = IDLE;
                    w_grant_nxt = '0;
                    w_count_nxt = '0;
                    w_rr_nxt    = r_owner;
                end else if (!full) begin
                    if (r_count == LW'(1)) begin
                        w_state_nxt = IDLE;
                        w_grant_nxt = '0;
                        w_count_nxt = '0;
                        w_rr_nxt    = r_owner;
                    end else begin
                        w_count_nxt = r_count - LW'(1);
                    end
                end
            end
            default: begin
                w_state_nxt = IDLE;
                w_grant_nxt = '0;
            end
        endcase
    end

    // State register with synchronous reset; rr starts so requester 0 leads.
    always_ff @(posedge clk) begin
        if (srst) begin
            r_state <= IDLE;
            r_grant <= '0;
            r_owner <= '0;
            r_count <= '0;
            r_rr    <= IW'(NREQ - 1);
        end else begin
            r_state <= w_state_nxt;
            r_grant <= w_grant_nxt;
            r_owner <= w_owner_nxt;
            r_count <= w_count_nxt;
            r_rr    <= w_rr_nxt;
        end
    end

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Self-checking bench for fifo_wr_arbiter: directed scenarios plus random
// traffic, compared every cycle against a burst-level reference model.
module tb_fifo_wr_arbiter;
    import fifo_ctrl_pkg::*;

    localparam int NREQ = 4;
    localparam int DW   = 8;
    localparam int GW   = 6;
    localparam int LW   = 4;
    localparam int IW   = 2;

    logic                clk;
    logic                srst;
    logic [NREQ-1:0]     req;
    logic [NREQ*LW-1:0]  len;
    logic [NREQ*DW-1:0]  din;
    logic                full;
    logic [GW-1:0]       gauge;
    logic [NREQ-1:0]     ack;
    logic [NREQ-1:0]     grant;
    logic                wen;
    logic [DW-1:0]       wdata;
    logic                busy;
    logic                abort;
    arb_state_t          dbg_state;
    logic [IW-1:0]       dbg_rr;

    fifo_wr_arbiter #(
        .NREQ (NREQ), .DW (DW), .GW (GW), .CAP (CAP), .LW (LW)
    ) dut (
        .clk (clk), .srst (srst), .req (req), .len (len), .din (din),
        .full (full), .gauge (gauge), .ack (ack), .grant (grant), .wen (wen),
        .wdata (wdata), .busy (busy), .abort (abort),
        .dbg_state (dbg_state), .dbg_rr (dbg_rr)
    );

    // Clock / reset block
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Checker
    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Reference model: one burst owner, words left, round-robin pointer.
    bit m_busy  = 1'b0;
    int m_owner = 0;
    int m_left  = 0;
    int m_rr    = NREQ - 1;

    // Scoreboard of words the model expects to reach the FIFO.
    logic [DW-1:0] exp_q[$];

    // Observed tallies for directed checks.
    int n_wen   = 0;
    int n_abort = 0;
    int starts[$];
    logic [NREQ-1:0] prev_grant = '0;

    function automatic int eff(input logic [LW-1:0] l);
        return (l == 0) ? 1 : int'(l);
    endfunction

    // One cycle: inputs are already set after a negedge; check, advance model.
    task automatic cycle();
        logic [NREQ-1:0] eg;
        logic            ew;
        logic [DW-1:0]   ed;
        logic            ea;
        int              c;
        int              free;
        #1;
        eg = '0;
        if (m_busy) eg[m_owner] = 1'b1;
        ew = m_busy && req[m_owner] && !full;
        ed = m_busy ? din[m_owner*DW +: DW] : '0;
        ea = m_busy && !req[m_owner];
        check("grant", grant, eg);
        check("wen", wen, ew);
        check("ack", ack, ew ? eg : '0);
        check("wdata", wdata, ed);
        check("busy", busy, m_busy);
        check("abort", abort, ea);
        check("state", dbg_state == XFER, m_busy);
        check("rr", dbg_rr, m_rr);
        if (ew) exp_q.push_back(ed);
        if (wen) begin
            if (exp_q.size() == 0) check("sb_extra", exp_q.size(), 1);
            else check("sb_data", wdata, exp_q.pop_front());
            n_wen++;
        end
        if (abort) n_abort++;
        if (grant != '0 && prev_grant == '0) begin
            for (int i = 0; i < NREQ; i++) if (grant[i]) starts.push_back(i);
        end
        prev_grant = grant;

        if (srst) begin
            m_busy = 1'b0;
            m_left = 0;
            m_rr   = NREQ - 1;
        end else if (!m_busy) begin
            free = (gauge > CAP) ? 0 : CAP - int'(gauge);
            c = -1;
            for (int k = 1; k <= NREQ; k++)
                if (c < 0 && req[(m_rr + k) % NREQ]) c = (m_rr + k) % NREQ;
            if (c >= 0 && eff(len[c*LW +: LW]) <= free) begin
                m_busy  = 1'b1;
                m_owner = c;
                m_left  = eff(len[c*LW +: LW]);
            end
        end else if (!req[m_owner]) begin
            m_busy = 1'b0;
            m_rr   = m_owner;
        end else if (!full) begin
            m_left--;
            if (m_left == 0) begin
                m_busy = 1'b0;
                m_rr   = m_owner;
            end
        end
        @(negedge clk);
    endtask

    task automatic do_reset();
        srst  = 1'b1;
        req   = '0;
        full  = 1'b0;
        gauge = '0;
        cycle();
        srst = 1'b0;
        n_wen   = 0;
        n_abort = 0;
        starts.delete();
    endtask

    // Random producer traffic with occasional stalls, overflows and resets.
    task automatic random_traffic(input int ncyc);
        for (int n = 0; n < ncyc; n++) begin
            for (int i = 0; i < NREQ; i++) begin
                if (!req[i]) begin
                    if ($urandom_range(0, 3) == 0) begin
                        req[i] = 1'b1;
                        len[i*LW +: LW] = LW'($urandom_range(0, 15));
                    end
                end else if ($urandom_range(0, 39) == 0) begin
                    req[i] = 1'b0;
                end
                if ($urandom_range(0, 19) == 0) len[i*LW +: LW] = LW'($urandom_range(0, 15));
            end
            din   = NREQ*DW'($urandom());
            gauge = GW'($urandom_range(0, 40));
            full  = ($urandom_range(0, 7) == 0);
            srst  = ($urandom_range(0, 299) == 0);
            cycle();
        end
        srst = 1'b0;
    endtask

    initial begin
        srst  = 1'b1;
        req   = '0;
        len   = '0;
        din   = '0;
        full  = 1'b0;
        gauge = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);

        // Reset values, then a single 4-word burst from requester 0.
        do_reset();
        check("rst_grant", grant, 0);
        check("rst_rr", dbg_rr, NREQ - 1);
        len = {4'd1, 4'd1, 4'd1, 4'd4};
        req = 4'b0001;
        repeat (5) cycle();
        req = '0;
        cycle();
        check("t1_wen", n_wen, 4);
        check("t1_rr", dbg_rr, 0);
        check("t1_starts", starts.size(), 1);

        // All requesting, 2-word bursts: order 0,1,2,3,0 with one bubble each.
        do_reset();
        len = 16'h2222;
        req = 4'b1111;
        repeat (15) cycle();
        req = '0;
        cycle();
        check("t2_nstarts", starts.size(), 5);
        if (starts.size() == 5) begin
            check("t2_o0", starts[0], 0);
            check("t2_o1", starts[1], 1);
            check("t2_o2", starts[2], 2);
            check("t2_o3", starts[3], 3);
            check("t2_o4", starts[4], 0);
        end
        check("t2_wen", n_wen, 10);

        // Room check: 3 words do not fit at gauge 30, do fit at 29.
        do_reset();
        len = {4'd1, 4'd1, 4'd1, 4'd3};
        req = 4'b0001;
        gauge = 6'd30;
        repeat (4) cycle();
        check("t3_blocked", starts.size(), 0);
        gauge = 6'd29;
        repeat (4) cycle();
        req = '0;
        cycle();
        check("t3_wen", n_wen, 3);
        check("t3_starts", starts.size(), 1);

        // Stall on full during a 5-word burst: all 5 words, no abort.
        do_reset();
        len = {4'd1, 4'd1, 4'd1, 4'd5};
        req = 4'b0001;
        repeat (2) cycle();
        full = 1'b1;
        repeat (2) cycle();
        full = 1'b0;
        repeat (4) cycle();
        req = '0;
        cycle();
        check("t4_wen", n_wen, 5);
        check("t4_abort", n_abort, 0);

        // Requester 1 drops after 2 of 6 words; requester 2 wins next.
        do_reset();
        len = {4'd1, 4'd2, 4'd6, 4'd1};
        req = 4'b0110;
        repeat (3) cycle();
        req = 4'b0100;
        cycle();
        check("t5_abort", n_abort, 1);
        check("t5_wen", n_wen, 2);
        check("t5_grant0", grant, 0);
        check("t5_rr", dbg_rr, 1);
        repeat (3) cycle();
        req = '0;
        cycle();
        check("t5_nstarts", starts.size(), 2);
        if (starts.size() == 2) check("t5_next", starts[1], 2);

        // Reset mid-burst: clean reset values, requester 0 wins again.
        do_reset();
        len = {4'd1, 4'd1, 4'd6, 4'd6};
        req = 4'b0011;
        repeat (3) cycle();
        srst = 1'b1;
        cycle();
        srst = 1'b0;
        #1;
        check("t6_grant", grant, 0);
        check("t6_wen", wen, 0);
        check("t6_busy", busy, 0);
        check("t6_abort", abort, 0);
        repeat (7) cycle();
        req = '0;
        cycle();
        check("t6_nstarts", starts.size(), 2);
        if (starts.size() == 2) check("t6_first", starts[1], 0);

        // Random traffic against the model.
        do_reset();
        random_traffic(2000);
        req = '0;
        full = 1'b0;
        repeat (20) cycle();
        check("sb_drain", exp_q.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
